instr_cache: RTL

Direct-mapped, read-only instruction cache in the fetch stage. It produces `icache_hit`, the signal the hazard unit consumes to stall fetch and flush decode. It returns the instruction for the current PC combinationally on a hit. On a miss it runs a line refill from the memory interface one word per beat.

---
 rtl/instr_cache.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instr_cache.sv
// instr_cache -- direct-mapped, read-only instruction cache for the fetch stage.
//
// A lookup is purely combinational: icache_hit and ic_out_instr follow
// f_in_pc in the same cycle while the controller is idle. A miss latches the
// line address and refills the whole line from the memory port one 32-bit
// word per response beat, in ascending word order. The refill is never
// aborted. A PC redirect during the refill is looked up once the controller
// is idle again.
//
// Optional build macro: ICACHE_PERF_CNT_EN adds hit and miss event counters.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   f_in_pc           fetch PC; bits [1:0] are ignored
//   f_in_invalidate   pulse; drops every line (fence.i)
//   icache_hit        PC hits and the controller is idle
//   ic_out_instr      instruction word for f_in_pc; valid only with icache_hit
//   mem_req_valid     refill request; held until mem_req_ready is sampled high
//   mem_req_addr      line-aligned refill address
//   mem_req_ready     memory accepts the refill request
//   mem_rsp_valid     response beat; no backpressure, ignored outside FILL
//   mem_rsp_data      response word
//   ic_out_hit_cnt    (ICACHE_PERF_CNT_EN only) idle cycles with a hit, wraps
//   ic_out_miss_cnt   (ICACHE_PERF_CNT_EN only) refills started, wraps
module instr_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] f_in_pc,
  input  logic              f_in_invalidate,
  output logic              icache_hit,
  output logic [31:0]       ic_out_instr,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       ic_out_hit_cnt,
  output logic [31:0]       ic_out_miss_cnt
`endif
);

  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  // Controller state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [WSEL_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              inv_pend_q, inv_pend_d;

  // Storage
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS_PER_LINE];

  // Address decomposition
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [WSEL_W-1:0] pc_word;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;

  assign pc_tag   = f_in_pc[ADDR_W-1 -: TAG_W];
  assign pc_idx   = f_in_pc[OFF_W +: IDX_W];
  assign pc_word  = f_in_pc[2 +: WSEL_W];
  assign fill_tag = fill_addr_q[ADDR_W-1 -: TAG_W];
  assign fill_idx = fill_addr_q[OFF_W +: IDX_W];

  // Byte-lane bits of the PC never select anything in a word-wide cache.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^f_in_pc[1:0];

  logic lookup_hit;
  logic miss_start;
  logic beat_we;
  logic last_beat;

  assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign miss_start = (state_q == IDLE) && !lookup_hit;
  assign beat_we    = (state_q == FILL) && mem_rsp_valid;
  assign last_beat  = beat_we && (beat_cnt_q == WSEL_W'(WORDS_PER_LINE - 1));

  assign icache_hit    = (state_q == IDLE) && lookup_hit;
  assign ic_out_instr  = data_q[pc_idx][pc_word];
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = fill_addr_q;

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    beat_cnt_d  = beat_cnt_q;
    inv_pend_d  = inv_pend_q;
    case (state_q)
      IDLE: begin
        if (!lookup_hit) begin
          state_d     = REQ;
          fill_addr_d = {pc_tag, pc_idx, {OFF_W{1'b0}}};
        end
      end
      REQ: begin
        // A fence.i while a refill is in flight must keep that line invalid.
        if (f_in_invalidate) inv_pend_d = 1'b1;
        if (mem_req_ready) begin
          state_d    = FILL;
          beat_cnt_d = '0;
        end
      end
      FILL: begin
        if (f_in_invalidate) inv_pend_d = 1'b1;
        if (mem_rsp_valid) begin
          beat_cnt_d = beat_cnt_q + WSEL_W'(1);
          if (last_beat) begin
            state_d    = IDLE;
            inv_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      beat_cnt_q  <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

  // Valid/tag/data arrays. An invalidate pulse wins over everything else, so
  // a final beat coinciding with it leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int l = 0; l < LINES; l++) begin
        tag_q[l] <= '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          data_q[l][w] <= '0;
        end
      end
    end else begin
      if (f_in_invalidate) begin
        valid_q <= '0;
      end else if (miss_start) begin
        valid_q[pc_idx] <= 1'b0;
      end else if (last_beat && !inv_pend_q) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (beat_we) data_q[fill_idx][beat_cnt_q] <= mem_rsp_data;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (icache_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign ic_out_hit_cnt  = hit_cnt_q;
  assign ic_out_miss_cnt = miss_cnt_q;
`endif

endmodule
